// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand path.
//   OPERAND_W      : width of one signed operand
//   operand_t      : one operand
//   packed_t       : two operands packed side by side (op1 in the upper half)
//   unpack_state_t : sequencing states of the operand unpacker
//   MIN_NEG        : most-negative operand; its two's-complement negation is
//                    not representable in OPERAND_W bits
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int unsigned OPERAND_W = 16;

    typedef logic [OPERAND_W-1:0]   operand_t;
    typedef logic [2*OPERAND_W-1:0] packed_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT_OP1,
        EMIT_OP2
    } unpack_state_t;

    localparam operand_t MIN_NEG = {1'b1, {(OPERAND_W-1){1'b0}}};

endpackage : alu_pkg

// File: rtl/twos_negate.sv
// -----------------------------------------------------------------------------
// twos_negate
// Purely combinational two's-complement negation of one operand.
// Ports:
//   i_val : operand to negate
//   o_neg : ~i_val + 1, truncated to WIDTH bits
//   o_ovf : high when i_val is the most-negative value (1 followed by zeros),
//           whose negation wraps back onto itself
// -----------------------------------------------------------------------------
module twos_negate #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_neg,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        o_neg = ~i_val + ONE;
        o_ovf = (i_val == MOST_NEG);
    end

endmodule : twos_negate

// File: rtl/operands_unpacker.sv
// -----------------------------------------------------------------------------
// operands_unpacker
// Receive end of the packed negated-operand word. A 2*WIDTH-bit word is taken
// over a valid/ready handshake, each half is re-negated to recover the original
// signed operand, and the two operands are streamed out serially, op1 then op2.
// Operands whose negation is not representable are flagged and counted.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : packed word present
//   in_ready   : word can be accepted this cycle (combinational)
//   in_data    : [2W-1:W] negated op1, [W-1:0] negated op2
//   out_valid  : out_data holds an operand
//   out_ready  : downstream accepts the operand
//   out_data   : recovered signed operand
//   out_sel    : 0 = op1, 1 = op2
//   out_last   : high with op2
//   out_ovf    : out_data came from the most-negative input half
//   ovf_count  : saturating count of emitted operands with out_ovf=1
//   ovf_clear  : synchronous clear of ovf_count (wins over an increment)
// -----------------------------------------------------------------------------
module operands_unpacker
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = OPERAND_W,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sel,
    output logic               out_last,
    output logic               out_ovf,
    output logic [CNT_W-1:0]   ovf_count,
    input  logic               ovf_clear
);

    unpack_state_t r_state;
    unpack_state_t w_state_next;

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_sel;
    logic             r_out_ovf;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_neg2;
    logic             r_ovf2;
    logic [CNT_W-1:0] r_ovf_count;

    logic [WIDTH-1:0] w_neg1;
    logic [WIDTH-1:0] w_neg2;
    logic             w_ovf1;
    logic             w_ovf2;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_hs;

    twos_negate #(.WIDTH(WIDTH)) u_neg_op1 (
        .i_val (in_data[2*WIDTH-1:WIDTH]),
        .o_neg (w_neg1),
        .o_ovf (w_ovf1)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_op2 (
        .i_val (in_data[WIDTH-1:0]),
        .o_neg (w_neg2),
        .o_ovf (w_ovf2)
    );

    assign w_accept = in_valid & w_in_ready;
    assign w_out_hs = r_out_valid & out_ready;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = EMIT_OP1;
                end
            end
            EMIT_OP1: begin
                if (out_ready) begin
                    w_state_next = EMIT_OP2;
                end
            end
            EMIT_OP2: begin
                if (out_ready) begin
                    w_state_next = w_accept ? EMIT_OP1 : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------ state outputs
    // A new word is only taken when the slot it lands in is free: from IDLE, or
    // as op2 leaves, which gives one word every two cycles with no bubble.
    always_comb begin
        w_in_ready = 1'b0;
        unique case (r_state)
            IDLE:     w_in_ready = 1'b1;
            EMIT_OP1: w_in_ready = 1'b0;
            EMIT_OP2: w_in_ready = out_ready;
            default:  w_in_ready = 1'b0;
        endcase
        if (rst) begin
            w_in_ready = 1'b0;
        end
    end

    // ----------------------------------------------------- output / hold path
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_neg2      <= '0;
            r_ovf2      <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_neg1;
            r_out_sel   <= 1'b0;
            r_out_ovf   <= w_ovf1;
            r_neg2      <= w_neg2;
            r_ovf2      <= w_ovf2;
        end else if (out_ready) begin
            if (r_state == EMIT_OP1) begin
                r_out_data <= r_neg2;
                r_out_sel  <= 1'b1;
                r_out_ovf  <= r_ovf2;
            end else if (r_state == EMIT_OP2) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // --------------------------------------------------------- overflow count
    always_ff @(posedge clk) begin
        if (rst || ovf_clear) begin
            r_ovf_count <= '0;
        end else if (w_out_hs && r_out_ovf && (r_ovf_count != '1)) begin
            r_ovf_count <= r_ovf_count + CNT_W'(1);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_last  = r_out_sel;
    assign out_ovf   = r_out_ovf;
    assign ovf_count = r_ovf_count;

endmodule : operands_unpacker

// File: tb/tb_operands_unpacker.sv
module tb_operands_unpacker;

    localparam int unsigned W = 16;
    localparam int unsigned C = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_sel;
    logic           out_last;
    logic           out_ovf;
    logic [C-1:0]   ovf_count;
    logic           ovf_clear;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
        logic         o;
    } item_t;

    operands_unpacker #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_ovf   (out_ovf),
        .ovf_count (ovf_count),
        .ovf_clear (ovf_clear)
    );

    always #5 clk = ~clk;

    // Arithmetic negation, independent of any bit-level formulation.
    function automatic logic [W-1:0] negv(input logic [W-1:0] x);
        int v;
        v = 0 - int'(x);
        return v[W-1:0];
    endfunction

    function automatic logic is_min(input logic [W-1:0] x);
        return x == 16'h8000;
    endfunction

    // Drive one cycle's inputs just after the falling edge; outputs are then
    // read mid-cycle, well away from the rising edge.
    task automatic cyc(input logic r, input logic v, input logic [2*W-1:0] d,
                       input logic rdy, input logic clr);
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; out_ready = rdy; ovf_clear = clr;
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 1, 32'hFFFF_FFFF, 1, 0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        cyc(1, 1, 32'hFFFF_FFFF, 1, 0);
        cyc(0, 0, 32'h0, 0, 0);
        checks++;
        if ({out_valid, out_data, out_sel, out_last, out_ovf, ovf_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h s=%b l=%b o=%b c=%h exp all 0",
                     out_valid, out_data, out_sel, out_last, out_ovf, ovf_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_idle_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [2*W-1:0] w;
        w = 32'hFFFB_0003;
        cyc(0, 1, w, 1, 0);
        cyc(0, 0, 32'h0, 1, 0);
        checks++;
        if ({out_valid, out_data, out_sel, out_last, out_ovf, in_ready} !==
            {1'b1, negv(w[31:16]), 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_op1 got v=%b d=%h s=%b l=%b o=%b r=%b exp d=%h",
                     out_valid, out_data, out_sel, out_last, out_ovf, in_ready, negv(w[31:16]));
        end
        cyc(0, 0, 32'h0, 1, 0);
        checks++;
        if ({out_valid, out_data, out_sel, out_last, out_ovf} !==
            {1'b1, 16'hFFFD, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_op2 got v=%b d=%h s=%b l=%b o=%b exp d=fffd s=1 l=1",
                     out_valid, out_data, out_sel, out_last, out_ovf);
        end
        cyc(0, 0, 32'h0, 1, 0);
        checks++;
        if ({out_valid, ovf_count} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL basic_end got v=%b c=%h exp v=0 c=00", out_valid, ovf_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [2*W-1:0] words [2];
        logic [W-1:0]   exp_d [4];
        logic           exp_r [5];
        words[0] = 32'h0001_0002;
        words[1] = 32'h0000_FFFF;
        for (int k = 0; k < 4; k++) begin
            logic [2*W-1:0] wk;
            wk = words[k/2];
            exp_d[k] = negv((k % 2 == 0) ? wk[31:16] : wk[15:0]);
        end
        exp_r = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 6; c++) begin
            cyc(0, (c < 3), (c < 2) ? words[0] : words[1], 1, 0);
            if (c < 5) begin
                checks++;
                if (in_ready !== exp_r[c]) begin
                    errors++;
                    $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_r[c]);
                end
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if ({out_valid, out_data, out_sel} !== {1'b1, exp_d[c-1], 1'((c - 1) % 2)}) begin
                    errors++;
                    $display("FAIL b2b_out cyc=%0d got v=%b d=%h s=%b exp d=%h",
                             c, out_valid, out_data, out_sel, exp_d[c-1]);
                end
            end
            if (c == 5) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle got v=%b exp=0", out_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [2*W-1:0] w;
        logic [2*W-1:0] w2;
        w  = 32'h1234_FEDC;
        w2 = 32'h5555_AAAA;
        cyc(0, 1, w, 1, 0);
        for (int c = 0; c < 4; c++) begin
            cyc(0, 1, w2, (c == 3), 0);
            checks++;
            if ({out_valid, out_data, out_sel, in_ready} !== {1'b1, negv(w[31:16]), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h s=%b r=%b exp d=%h s=0 r=0",
                         c, out_valid, out_data, out_sel, in_ready, negv(w[31:16]));
            end
        end
        cyc(0, 0, w2, 1, 0);
        checks++;
        if ({out_valid, out_data, out_sel} !== {1'b1, negv(w[15:0]), 1'b1}) begin
            errors++;
            $display("FAIL bp_op2 got v=%b d=%h s=%b exp d=%h", out_valid, out_data, out_sel, negv(w[15:0]));
        end
        cyc(0, 0, w2, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_extra got v=%b exp=0", out_valid);
        end
    endtask

    task automatic test_overflow;
        logic [2*W-1:0] w;
        w = 32'h8000_8000;
        cyc(0, 1, w, 1, 0);
        for (int c = 0; c < 2; c++) begin
            cyc(0, 0, 32'h0, 1, 0);
            checks++;
            if ({out_valid, out_data, out_ovf, out_sel} !== {1'b1, 16'h8000, 1'b1, 1'(c)}) begin
                errors++;
                $display("FAIL ovf_out%0d got v=%b d=%h o=%b s=%b exp d=8000 o=1",
                         c, out_valid, out_data, out_ovf, out_sel);
            end
        end
        cyc(0, 0, 32'h0, 1, 0);
        checks++;
        if (ovf_count !== 8'd2) begin
            errors++; $display("FAIL ovf_count2 got=%h exp=02", ovf_count);
        end
        // 300 more overflowing operands: 2 + 300 must stop at all-ones.
        for (int c = 0; c < 300; c++) cyc(0, 1, w, 1, 0);
        cyc(0, 0, w, 1, 0);
        cyc(0, 0, w, 1, 0);
        checks++;
        if (ovf_count !== 8'hFF) begin
            errors++; $display("FAIL ovf_saturate got=%h exp=ff", ovf_count);
        end
        cyc(0, 1, w, 1, 0);
        cyc(0, 0, w, 1, 1);
        cyc(0, 0, w, 1, 0);
        checks++;
        if (ovf_count !== 8'h00) begin
            errors++; $display("FAIL ovf_clear_prio got=%h exp=00", ovf_count);
        end
        cyc(0, 0, w, 1, 0);
        checks++;
        if (ovf_count !== 8'h01) begin
            errors++; $display("FAIL ovf_after_clear got=%h exp=01", ovf_count);
        end
    endtask

    task automatic test_reset_mid;
        logic [2*W-1:0] w;
        w = 32'h0007_0009;
        cyc(0, 1, 32'h0011_0022, 1, 0);
        cyc(1, 0, 32'h0, 0, 0);
        cyc(0, 1, w, 1, 0);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL rstmid_idle got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        cyc(0, 0, 32'h0, 1, 0);
        checks++;
        if ({out_valid, out_data, out_sel} !== {1'b1, negv(w[31:16]), 1'b0}) begin
            errors++;
            $display("FAIL rstmid_op1 got v=%b d=%h s=%b exp d=%h", out_valid, out_data, out_sel, negv(w[31:16]));
        end
        cyc(0, 0, 32'h0, 1, 0);
        checks++;
        if ({out_valid, out_data, out_sel} !== {1'b1, negv(w[15:0]), 1'b1}) begin
            errors++;
            $display("FAIL rstmid_op2 got v=%b d=%h s=%b exp d=%h", out_valid, out_data, out_sel, negv(w[15:0]));
        end
        cyc(0, 0, 32'h0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_stale got v=%b exp=0", out_valid);
        end
    endtask

    function automatic logic [W-1:0] pick_half();
        case ($urandom_range(7))
            0:       return 16'h8000;
            1:       return 16'h0000;
            2:       return 16'h7FFF;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random;
        item_t       q[$];
        int unsigned mcnt;
        logic        v, r, clr, exp_rdy, hs_ovf, hs;
        logic [W-1:0] hi, lo;
        cyc(1, 0, 32'h0, 0, 0);
        mcnt = 0;
        for (int i = 0; i < 10010; i++) begin
            hi  = pick_half();
            lo  = pick_half();
            v   = (i < 10000) ? 1'($urandom_range(1)) : 1'b0;
            r   = (i < 10000) ? ($urandom_range(3) != 0) : 1'b1;
            clr = ($urandom_range(49) == 0);
            cyc(0, v, {hi, lo}, r, clr);
            // Queue depth tells where the block is: 0 idle, 2 op1 showing, 1 op2 showing.
            exp_rdy = (q.size() == 0) || (q.size() == 1 && r);
            checks++;
            if ({in_ready, out_valid, ovf_count} !== {exp_rdy, (q.size() != 0), C'(mcnt)}) begin
                errors++;
                $display("FAIL rnd_ctrl i=%0d got r=%b v=%b c=%h exp r=%b v=%b c=%h",
                         i, in_ready, out_valid, ovf_count, exp_rdy, (q.size() != 0), C'(mcnt));
            end
            hs = 1'b0;
            hs_ovf = 1'b0;
            if (q.size() != 0) begin
                checks++;
                if ({out_data, out_sel, out_last, out_ovf} !== {q[0].d, q[0].s, q[0].s, q[0].o}) begin
                    errors++;
                    $display("FAIL rnd_data i=%0d got d=%h s=%b l=%b o=%b exp d=%h s=%b o=%b",
                             i, out_data, out_sel, out_last, out_ovf, q[0].d, q[0].s, q[0].o);
                end
                if (r) begin
                    hs = 1'b1;
                    hs_ovf = q[0].o;
                    void'(q.pop_front());
                end
            end
            if (v && exp_rdy) begin
                q.push_back('{d: negv(hi), s: 1'b0, o: is_min(hi)});
                q.push_back('{d: negv(lo), s: 1'b1, o: is_min(lo)});
            end
            if (clr) mcnt = 0;
            else if (hs && hs_ovf && mcnt < 255) mcnt++;
        end
        cyc(0, 0, 32'h0, 1, 0);
        checks++;
        if ((q.size() != 0) || (out_valid !== 1'b0)) begin
            errors++;
            $display("FAIL rnd_drain got pending=%0d v=%b exp pending=0 v=0", q.size(), out_valid);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clear = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_operands_unpacker

// File: doc/operands_unpacker.md
Name: operands_unpacker

Overview:
- Receive end of the packed negated-operand word produced by the ALU operand path.
- Accepts one 2*WIDTH-bit packed word over a valid/ready handshake and splits it into its two halves.
- Re-negates each half in two's complement to recover the original signed operands.
- Emits the operands serially, op1 then op2, on a WIDTH-bit valid/ready stream, and flags and counts the non-invertible value (most-negative number).

Parameters:
- WIDTH, 16, width of one operand; packed input is 2*WIDTH.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  packed word present
- in_ready  output  1  block can accept packed word this cycle
- in_data  input  2*WIDTH  packed word; [2*WIDTH-1:WIDTH] = negated op1, [WIDTH-1:0] = negated op2
- out_valid  output  1  out_data holds an operand
- out_ready  input  1  downstream accepts operand
- out_data  output  WIDTH  recovered signed operand
- out_sel  output  1  0 = op1, 1 = op2
- out_last  output  1  high with op2 (equals out_sel)
- out_ovf  output  1  current out_data came from input half 1 followed by WIDTH-1 zeros (negation not representable)
- ovf_count  output  CNT_W  saturating count of emitted operands with out_ovf=1
- ovf_clear  input  1  synchronous clear of ovf_count

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - out_valid, out_data, out_sel, out_last, out_ovf and ovf_count are all 0.
  - Holding registers are 0.
  - in_ready is 0 during the reset cycle.
- States: IDLE, EMIT_OP1, EMIT_OP2.
- in_ready is combinational: 1 in IDLE; 1 in EMIT_OP2 when out_ready=1; 0 otherwise.
- Input accept = in_valid & in_ready. On accept:
  - Register neg1 = -in_data[2*WIDTH-1:WIDTH] and neg2 = -in_data[WIDTH-1:0], each computed as (~x + 1) truncated to WIDTH.
  - Register their ovf bits; ovf = (x == 1 followed by WIDTH-1 zeros), i.e. 16'h8000 for WIDTH=16.
  - out_data = neg1, out_sel = 0, out_valid = 1. Go to EMIT_OP1.
  - Latency from accept to op1 visible: 1 cycle.
- EMIT_OP1: hold all outputs stable while out_ready=0. On out_ready=1, present neg2 with out_sel=1 and out_ovf = op2 ovf, and go to EMIT_OP2.
- EMIT_OP2: on out_ready=1 with an input accept in the same cycle, load the new word and go to EMIT_OP1. This is back-to-back operation: one packed word per 2 cycles, no bubble.
- EMIT_OP2: on out_ready=1 without an accept, out_valid = 0 and go to IDLE.
- out_valid, once high, never drops before its handshake; out_data, out_sel and out_ovf are stable while out_valid=1 and out_ready=0.
- Zero input half gives output 0 with ovf=0.
- ovf_count:
  - Increments by 1 on each output handshake with out_ovf=1, and saturates at all-ones.
  - ovf_clear has priority over an increment in the same cycle; the result is 0.
- Reset mid-operation discards any held word; the next cycle is IDLE with out_valid=0.
- in_data is ignored when no accept occurs.

Decomposition:
- Shared package alu_pkg:
  - Constant OPERAND_W = 16.
  - Typedef operand_t of OPERAND_W bits.
  - Typedef packed_t of 2*OPERAND_W bits.
  - State enum unpack_state_t {IDLE, EMIT_OP1, EMIT_OP2}.
  - Function-free constant MIN_NEG = 1 followed by OPERAND_W-1 zeros.
- Sub-module twos_negate (WIDTH parameter):
  - Combinational output out = ~in + 1 and flag ovf.
  - Instantiated twice, once per half.
- FSM, holding registers and counter stay in the top module.

Test Plan:
- Reset, then in_data = 32'hFFFB_0003 with out_ready held 1 -> op1 = 16'h0005 (sel 0, last 0), then op2 = 16'hFFFD (sel 1, last 1); out_ovf 0 both; ovf_count 0.
- Back-to-back: two words 32'h0001_0002 and 32'h0000_FFFF with in_valid and out_ready held 1 -> outputs FFFF, FFFE, 0000, 0001 on consecutive cycles; in_ready high only in the first IDLE cycle and the EMIT_OP2 cycles.
- Backpressure: out_ready low for 3 cycles in EMIT_OP1 -> out_data and sel unchanged, in_ready 0, no extra words accepted.
- Overflow: in_data = 32'h8000_8000 -> both outputs 16'h8000 with out_ovf 1; ovf_count becomes 2. Then 300 such operands -> saturates at 8'hFF. Then ovf_clear together with an ovf handshake -> 0.
- Reset asserted in EMIT_OP1 -> next cycle out_valid 0 and in_ready 1. A new word then emits normally with no stale op2.
- Random packed words with random out_ready over 10k cycles -> the scoreboard receives out = -in per half, ordered op1 before op2, with no loss or duplication.
